lfsr_generator: RTL

LFSR_GENERATOR -- requirements
Module: lfsr_generator

---
 rtl/lfsr_generator.sv | 110 +++++++++++
 1 files changed

// File: rtl/lfsr_generator.sv
// 16-bit de Bruijn LFSR word generator with a soft reseed, a word counter and
// a small error injector that flips bit 0 of a burst of output words.
module lfsr_generator #(
  parameter int DEF_SEED      = 300,
  parameter int CORRUPT_WORDS = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_soft_reset,
  input  logic [15:0] i_seed,
  input  logic        i_valid,
  input  logic        i_corrupt,
  output logic [15:0] o_LFSR,
  output logic        o_valid,
  output logic        o_corrupting,
  output logic [15:0] o_word_count
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} inj_state_e;

  localparam logic [15:0] SEED_RST  = 16'(DEF_SEED);
  localparam logic [15:0] BURST_LEN = 16'(CORRUPT_WORDS);
  localparam bit          INJ_EN    = (CORRUPT_WORDS > 0);

  logic [15:0] s_q, s_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        vld_q, vld_d;
  logic [15:0] wcnt_q, wcnt_d;
  inj_state_e  state_q, state_d;
  logic [15:0] burst_q, burst_d;

  // The (S[14:0]==0) term splices 0x0000 into the cycle, giving all 2^16 states.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic        fb;
    logic [15:0] n;
    fb   = s[15] ^ (s[14:0] == 15'd0);
    n    = {s[14:0], fb};
    n[2] = n[2] ^ fb;
    n[3] = n[3] ^ fb;
    n[5] = n[5] ^ fb;
    return n;
  endfunction

  // Next-state: reseed wins, then LFSR step, then injector state machine.
  always_comb begin
    s_d     = s_q;
    lfsr_d  = lfsr_q;
    vld_d   = 1'b0;
    wcnt_d  = wcnt_q;
    state_d = state_q;
    burst_d = burst_q;
    if (i_soft_reset) begin
      s_d     = i_seed;
      lfsr_d  = 16'h0000;
      wcnt_d  = 16'h0000;
      state_d = IDLE;
      burst_d = 16'h0000;
    end else begin
      if (i_valid) begin
        s_d    = lfsr_next(s_q);
        // Mask touches only the emitted word; S always advances clean.
        lfsr_d = lfsr_next(s_q) ^ {15'd0, state_q == BURST};
        vld_d  = 1'b1;
        wcnt_d = wcnt_q + 16'd1;
      end
      case (state_q)
        IDLE: begin
          // Request is only armed here; the first corrupted word is the next step.
          if (i_corrupt && INJ_EN) begin
            state_d = BURST;
            burst_d = BURST_LEN;
          end
        end
        BURST: begin
          // i_corrupt is ignored in BURST, so a held request leaves a clean gap.
          if (i_valid) begin
            burst_d = burst_q - 16'd1;
            if (burst_q == 16'd1) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; async reset also cancels any burst in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s_q     <= SEED_RST;
      lfsr_q  <= 16'h0000;
      vld_q   <= 1'b0;
      wcnt_q  <= 16'h0000;
      state_q <= IDLE;
      burst_q <= 16'h0000;
    end else begin
      s_q     <= s_d;
      lfsr_q  <= lfsr_d;
      vld_q   <= vld_d;
      wcnt_q  <= wcnt_d;
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  assign o_LFSR       = lfsr_q;
  assign o_valid      = vld_q;
  assign o_corrupting = (state_q == BURST);
  assign o_word_count = wcnt_q;

endmodule
